// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period/frequency measurement channels.
package period_meter_pkg;

  // Measurement FSM: IDLE waits for an opening edge, MEAS has a window open.
  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // Defaults shared with the frequency-calculation block.
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_AVG_LOG2    = 0;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 100000000;

  // Number of rising edges that close one averaging window.
  function automatic int unsigned window_edges(input int unsigned avg_log2);
    return 32'd1 << avg_log2;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input plus rising-edge detect.
// The pin-to-rise latency is fixed, so downstream period counts are unbiased.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_d;

  // Shift the raw input through the synchroniser and keep one delayed copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      q_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      q_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_sync = sync_q[SYNC_STAGES-1];
  assign rise   = q_sync & ~q_d;

endmodule

// File: rtl/period_meter.sv
// Single-channel period / high-time meter averaged over 2^AVG_LOG2 periods.
// Output handshake: valid and timeout are single-cycle strobes with no ready;
// the consumer must take period/high_time in the cycle valid is high. The
// values then hold until the next valid (or reset).
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sigin,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned      ECNT_W      = AVG_LOG2 + 1;
  localparam logic [ECNT_W-1:0] LAST_EDGE  = ECNT_W'(window_edges(AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [ECNT_W-1:0] ECNT_ONE   = ECNT_W'(1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [CNT_W-1:0]    hacc, hacc_nx;
  logic [ECNT_W-1:0]   ecnt, ecnt_nx;
  logic [CNT_W-1:0]    period_nx, high_nx;
  logic                valid_nx, timeout_nx;
  logic                s, rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_async(sigin),
    .q_sync (s),
    .rise   (rise)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and datapath update: window open, accumulate, close, timeout.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hacc_nx    = hacc;
    ecnt_nx    = ecnt;
    period_nx  = period;
    high_nx    = high_time;
    valid_nx   = 1'b0;
    timeout_nx = 1'b0;
    if (!en) begin
      // Disabling discards any open window silently; outputs hold.
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = MEAS;
            cnt_nx   = CNT_ONE;
            hacc_nx  = CNT_ONE;
            ecnt_nx  = '0;
          end
        end
        MEAS: begin
          if (rise) begin
            if (ecnt == LAST_EDGE) begin
              // Closing edge also opens the next window (continuous mode).
              period_nx = cnt >> AVG_LOG2;
              high_nx   = hacc >> AVG_LOG2;
              valid_nx  = 1'b1;
              cnt_nx    = CNT_ONE;
              hacc_nx   = CNT_ONE;
              ecnt_nx   = '0;
            end else begin
              cnt_nx  = cnt + CNT_ONE;
              hacc_nx = hacc + CNT_W'(s);
              ecnt_nx = ecnt + ECNT_ONE;
            end
          end else if (cnt == TIMEOUT_VAL) begin
            // A rise in this same cycle would have won above.
            timeout_nx = 1'b1;
            state_nx   = IDLE;
          end else begin
            cnt_nx  = cnt + CNT_ONE;
            hacc_nx = hacc + CNT_W'(s);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      hacc      <= '0;
      ecnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      hacc      <= hacc_nx;
      ecnt      <= ecnt_nx;
      period    <= period_nx;
      high_time <= high_nx;
      valid     <= valid_nx;
      timeout   <= timeout_nx;
    end
  end

  assign busy = (state == MEAS);

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: three instances with different averaging/timeout
// settings share one stimulus stream; a timestamp-based reference model
// predicts every valid/timeout strobe and the held output values.
module tb_period_meter;

  localparam int NI   = 3;
  localparam int MAXC = 30000;
  localparam int EW   = 97;  // {kind, stamp[32], period[32], high[32]}
  localparam int AL[NI] = '{0, 2, 1};
  localparam int TO[NI] = '{50, 400, 100};
  localparam int SY[NI] = '{2, 3, 2};

  logic        clk, rst, sigin, en;
  logic [31:0] period_w[NI];
  logic [31:0] high_w[NI];
  logic        valid_w[NI], timeout_w[NI], busy_w[NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vf     = 0;

  bit raw[MAXC];
  bit s_at[NI][MAXC];
  bit          open_m[NI];
  int          ws_m[NI];
  int          ed_m[NI];
  logic [31:0] lp_m[NI], lh_m[NI];
  logic [EW-1:0] exp_q[NI][$];

  period_meter #(.CNT_W(32), .AVG_LOG2(AL[0]), .SYNC_STAGES(SY[0]), .TIMEOUT_CYC(TO[0])) dut_a (
    .clk(clk), .rst(rst), .sigin(sigin), .en(en), .period(period_w[0]), .high_time(high_w[0]),
    .valid(valid_w[0]), .timeout(timeout_w[0]), .busy(busy_w[0]));
  period_meter #(.CNT_W(32), .AVG_LOG2(AL[1]), .SYNC_STAGES(SY[1]), .TIMEOUT_CYC(TO[1])) dut_b (
    .clk(clk), .rst(rst), .sigin(sigin), .en(en), .period(period_w[1]), .high_time(high_w[1]),
    .valid(valid_w[1]), .timeout(timeout_w[1]), .busy(busy_w[1]));
  period_meter #(.CNT_W(32), .AVG_LOG2(AL[2]), .SYNC_STAGES(SY[2]), .TIMEOUT_CYC(TO[2])) dut_c (
    .clk(clk), .rst(rst), .sigin(sigin), .en(en), .period(period_w[2]), .high_time(high_w[2]),
    .valid(valid_w[2]), .timeout(timeout_w[2]), .busy(busy_w[2]));

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", name, i, cyc, got, want);
    end
  endtask

  // Reference model step for instance i at clock edge j, working on edge
  // timestamps: a window spans from its opening rise to the N-th later rise.
  task automatic model_step(input int i, input int j);
    bit s, sd, rise;
    int tot, hi;
    s  = 1'b0;
    sd = 1'b0;
    if (j - SY[i] >= vf)     s  = raw[j - SY[i]];
    if (j - SY[i] - 1 >= vf) sd = raw[j - SY[i] - 1];
    s_at[i][j] = s;
    rise = s & ~sd;
    if (!en) begin
      open_m[i] = 1'b0;
    end else if (!open_m[i]) begin
      if (rise) begin
        open_m[i] = 1'b1;
        ws_m[i]   = j;
        ed_m[i]   = 0;
      end
    end else if (rise) begin
      ed_m[i]++;
      if (ed_m[i] == (1 << AL[i])) begin
        tot = j - ws_m[i];
        hi  = 0;
        for (int c = ws_m[i]; c < j; c++) hi += int'(s_at[i][c]);
        lp_m[i] = 32'(tot >> AL[i]);
        lh_m[i] = 32'(hi >> AL[i]);
        exp_q[i].push_back({1'b0, 32'(j + 1), lp_m[i], lh_m[i]});
        ws_m[i] = j;
        ed_m[i] = 0;
      end
    end else if (j - ws_m[i] == TO[i]) begin
      exp_q[i].push_back({1'b1, 32'(j + 1), lp_m[i], lh_m[i]});
      open_m[i] = 1'b0;
    end
  endtask

  // Model process: samples inputs at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
        $fatal(1, "cycle budget exceeded");
      end
      raw[cyc] = sigin;
      if (!rst) begin
        vf = cyc + 1;
        for (int i = 0; i < NI; i++) begin
          open_m[i] = 1'b0;
          lp_m[i]   = '0;
          lh_m[i]   = '0;
          exp_q[i].delete();
        end
      end else begin
        for (int i = 0; i < NI; i++) model_step(i, cyc);
      end
      cyc++;
    end
  end

  // Scoreboard monitor: pops expected strobes and checks held outputs.
  task automatic check_inst(input int i);
    logic [EW-1:0] e;
    while (exp_q[i].size() > 0 && int'(exp_q[i][0][95:64]) < cyc) begin
      e = exp_q[i].pop_front();
      checks++;
      errors++;
      $display("FAIL missed_strobe inst=%0d cyc=%0d got=none want_kind=%0d at=%0d", i, cyc, e[96], e[95:64]);
    end
    if (valid_w[i] || timeout_w[i]) begin
      checks++;
      if (valid_w[i] && timeout_w[i]) begin
        errors++;
        $display("FAIL both_strobes inst=%0d cyc=%0d got=valid+timeout want=one", i, cyc);
      end else if (exp_q[i].size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe inst=%0d cyc=%0d got_timeout=%0d want=none", i, cyc, timeout_w[i]);
      end else begin
        e = exp_q[i].pop_front();
        if (e[96] !== timeout_w[i] || int'(e[95:64]) != cyc) begin
          errors++;
          $display("FAIL strobe inst=%0d cyc=%0d got_timeout=%0d want_timeout=%0d want_at=%0d",
                   i, cyc, timeout_w[i], e[96], e[95:64]);
        end
      end
    end
    chk("busy", i, 32'(busy_w[i]), 32'(open_m[i]));
    chk("period", i, period_w[i], lp_m[i]);
    chk("high_time", i, high_w[i], lh_m[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) for (int i = 0; i < NI; i++) check_inst(i);
    end
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic put(input bit v);
    @(negedge clk);
    sigin = v;
  endtask

  task automatic sq(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < per; c++) put(c < hi);
  endtask

  // Stimulus.
  initial begin
    int per, hi;
    rst = 1'b0; sigin = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_period", i, period_w[i], 32'd0);
      chk("reset_high", i, high_w[i], 32'd0);
      chk("reset_busy", i, 32'(busy_w[i]), 32'd0);
    end
    #2 rst = 1'b1;

    sq(10, 5, 30);                              // square wave, 50% duty
    sq(37, 9, 12);                              // 37 / 9
    for (int k = 0; k < 10; k++) begin          // alternating 10 / 11
      sq(10, 5, 1);
      sq(11, 5, 1);
    end
    repeat (450) put(1'b0);                     // timeout from open window
    sq(3, 3, 1);                                // single rise from IDLE
    repeat (450) put(1'b0);                     // then held low

    for (int k = 0; k < 12; k++)                // en dropped mid-window
      for (int c = 0; c < 10; c++) begin
        if (k == 3 && c == 4) en = 1'b0;
        if (k == 6 && c == 4) en = 1'b1;
        put(c < 5);
      end

    sq(10, 5, 4);                               // async reset mid-window
    repeat (4) put(1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("arst_period", i, period_w[i], 32'd0);
      chk("arst_high", i, high_w[i], 32'd0);
      chk("arst_valid", i, 32'(valid_w[i]), 32'd0);
      chk("arst_timeout", i, 32'(timeout_w[i]), 32'd0);
      chk("arst_busy", i, 32'(busy_w[i]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    sq(10, 5, 12);

    for (int k = 0; k < 150; k++) begin         // randomized periods/duty
      per = int'($urandom_range(45, 4));
      hi  = int'($urandom_range(per - 1, 1));
      sq(per, hi, 1);
    end

    repeat (10) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      while (exp_q[i].size() > 0) begin
        checks++;
        errors++;
        $display("FAIL pending_strobe inst=%0d got=none want_at=%0d", i, exp_q[i][0][95:64]);
        void'(exp_q[i].pop_front());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
